instr_cache_sa: RTL and testbench

Parametrised N-way set-associative, read-only instruction cache between the CPU fetch stage and instruction memory. Next generation of the direct-mapped 8-line instruction cache: configurable address width, line size, set count and associativity, with round-robin replacement and a synchronous flush. Hits return the instruction combinationally; misses stall the CPU via busywait while a whole line is fetched from memory.

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_set_ctrl.sv | 52 +++++
 rtl/instr_cache_sa.sv | 205 ++++++++++++++++++++
 tb/tb_instr_cache_sa.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types, default geometry and helpers for the
//               set-associative instruction cache (instr_cache_sa).
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  // Controller states: serving hits, or waiting on a line refill
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_READ = 1'b1
  } state_t;

  // Default geometry
  localparam int C_ADDR_W     = 10;
  localparam int C_WORD_W     = 32;
  localparam int C_LINE_WORDS = 4;
  localparam int C_SETS       = 8;
  localparam int C_WAYS       = 2;

  // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_set_ctrl
// Description : Tag compare across the ways of one (indexed) set, hit-way
//               encode and victim selection (lowest invalid way, else the
//               set's round-robin pointer). Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_set_ctrl
  import icache_pkg::*;
#(
  parameter int TAG_W = 3,
  parameter int WAYS  = C_WAYS,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]       i_set_valid,
  input  logic [WAYS*TAG_W-1:0] i_set_tags,
  input  logic [TAG_W-1:0]      i_req_tag,
  input  logic [WAY_W-1:0]      i_victim_ptr,
  output logic                  o_hit,
  output logic [WAY_W-1:0]      o_hit_way,
  output logic [WAY_W-1:0]      o_victim_way
);

  logic [WAYS-1:0] w_match;

  // One comparator per way
  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_match
      assign w_match[g] = i_set_valid[g] && (i_set_tags[g*TAG_W +: TAG_W] == i_req_tag);
    end
  endgenerate

  // Encode the (at most one) matching way
  always_comb begin
    o_hit     = |w_match;
    o_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_match[i]) o_hit_way = WAY_W'(i);
    end
  end

  // Prefer an empty way (descending scan so the lowest index wins)
  always_comb begin
    o_victim_way = i_victim_ptr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_set_valid[i]) o_victim_way = WAY_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_cache_sa.sv
`default_nettype none
// ============================================================================
// Module      : instr_cache_sa
// Description : N-way set-associative read-only instruction cache. Hits
//               return combinationally; misses stall via busywait while a
//               whole line is fetched. Round-robin replacement, flush.
//               Optional macro INSTR_CACHE_PERF_EN adds hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_cache_sa
  import icache_pkg::*;
#(
  parameter int ADDR_W     = C_ADDR_W,
  parameter int WORD_W     = C_WORD_W,
  parameter int LINE_WORDS = C_LINE_WORDS,   // at least 2
  parameter int SETS       = C_SETS,         // at least 2
  parameter int WAYS       = C_WAYS
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [ADDR_W-1:0]                             address,
  input  logic                                          flush,
  output logic [WORD_W-1:0]                             readdata,
  output logic                                          busywait,
  output logic                                          mem_read,
  output logic [ADDR_W-clog2(LINE_WORDS*WORD_W/8)-1:0]  mem_address,
  input  logic [WORD_W*LINE_WORDS-1:0]                  mem_readdata,
  input  logic                                          mem_busywait
`ifdef INSTR_CACHE_PERF_EN
  ,
  output logic [31:0]                                   hit_count,
  output logic [31:0]                                   miss_count
`endif
);

  localparam int C_BYTE_W = clog2(WORD_W / 8);
  localparam int C_OFF_W  = clog2(LINE_WORDS * WORD_W / 8);
  localparam int C_WSEL_W = C_OFF_W - C_BYTE_W;
  localparam int C_IDX_W  = clog2(SETS);
  localparam int C_TAG_W  = ADDR_W - C_OFF_W - C_IDX_W;
  localparam int C_WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1;

  // Storage: valid bits and pointers are reset, tags and data are not
  logic [LINE_WORDS-1:0][WORD_W-1:0] r_data  [SETS][WAYS];
  logic [C_TAG_W-1:0]                r_tag   [SETS][WAYS];
  logic [WAYS-1:0]                   r_valid [SETS];
  logic [C_WAY_W-1:0]                r_ptr   [SETS];
  logic                              r_flush_pend;
  state_t                            r_state, w_state_next;

  logic [C_TAG_W-1:0]                w_tag;
  logic [C_IDX_W-1:0]                w_idx;
  logic [C_WSEL_W-1:0]               w_wsel;
  logic [WAYS*C_TAG_W-1:0]           w_set_tags;
  logic                              w_hit;
  logic [C_WAY_W-1:0]                w_hit_way;
  logic [C_WAY_W-1:0]                w_victim;
  logic [C_WAY_W-1:0]                w_ptr_next;
  logic [LINE_WORDS-1:0][WORD_W-1:0] w_line;
  logic                              w_fill_edge;
  logic                              w_install;
  logic                              w_clear_all;
  logic                              w_unused_byte_bits;

  assign w_tag  = address[ADDR_W-1 -: C_TAG_W];
  assign w_idx  = address[C_OFF_W +: C_IDX_W];
  assign w_wsel = address[C_BYTE_W +: C_WSEL_W];
  assign w_unused_byte_bits = ^address[C_BYTE_W-1:0];

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_pack_tags
      assign w_set_tags[g*C_TAG_W +: C_TAG_W] = r_tag[w_idx][g];
    end
  endgenerate

  icache_set_ctrl #(
    .TAG_W (C_TAG_W),
    .WAYS  (WAYS),
    .WAY_W (C_WAY_W)
  ) u_set_ctrl (
    .i_set_valid  (r_valid[w_idx]),
    .i_set_tags   (w_set_tags),
    .i_req_tag    (w_tag),
    .i_victim_ptr (r_ptr[w_idx]),
    .o_hit        (w_hit),
    .o_hit_way    (w_hit_way),
    .o_victim_way (w_victim)
  );

  assign w_line   = r_data[w_idx][w_hit_way];
  assign readdata = w_line[w_wsel];

  // A power-of-two pointer wraps by itself; a single way pins it at zero
  assign w_ptr_next = (WAYS == 1) ? '0 : r_ptr[w_idx] + 1'b1;

  // Fill edge: memory data valid this cycle. A flush seen at any point
  // during the refill (pending or on this very edge) discards the line.
  assign w_fill_edge = (r_state == MEM_READ) && !mem_busywait;
  assign w_install   = w_fill_edge && !r_flush_pend && !flush;
  assign w_clear_all = ((r_state == IDLE) && flush) ||
                       (w_fill_edge && (r_flush_pend || flush));

  // Next-state and handshake outputs; a flush in IDLE holds the FSM there
  always_comb begin
    w_state_next = r_state;
    busywait     = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;
    case (r_state)
      IDLE: begin
        busywait = !w_hit || flush;
        if (!flush && !w_hit) w_state_next = MEM_READ;
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = address[ADDR_W-1:C_OFF_W];
        if (!mem_busywait) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, valid bits, victim pointers and the pending-flush latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_clear_all) begin
        r_flush_pend <= 1'b0;
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_ptr[s]   <= '0;
        end
      end else begin
        if ((r_state == MEM_READ) && flush) r_flush_pend <= 1'b1;
        if (w_install) begin
          r_valid[w_idx][w_victim] <= 1'b1;
          r_ptr[w_idx]             <= w_ptr_next;
        end
      end
    end
  end

  // Line and tag write on an accepted fill
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_data[w_idx][w_victim] <= mem_readdata;
      r_tag[w_idx][w_victim]  <= w_tag;
    end
  end

`ifdef INSTR_CACHE_PERF_EN
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_vld;
  logic              w_count_hit;
  logic              w_count_miss;

  // Re-reading the same address while idle is not a new fetch
  assign w_count_hit  = (r_state == IDLE) && w_hit && !flush &&
                        (!r_last_vld || (address != r_last_addr));
  assign w_count_miss = (r_state == IDLE) && (w_state_next == MEM_READ);

  // Saturating hit/miss counters, cleared by reset and flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_last_addr  <= '0;
      r_last_vld   <= 1'b0;
    end else if (flush) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_last_vld   <= 1'b0;
    end else begin
      if (w_count_hit) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
        r_last_addr <= address;
        r_last_vld  <= 1'b1;
      end
      if (w_count_miss && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

`ifndef SYNTHESIS
  // The CPU must hold the fetch address while it is stalled
  a_addr_stable_while_busy: assert property (
    @(posedge clk) disable iff (!reset) busywait |=> $stable(address)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_cache_sa.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_cache_sa
// Description : Self-checking bench for instr_cache_sa (default geometry:
//               10-bit address, 16-byte lines, 8 sets, 2 ways). Scoreboard
//               queue fed by the driver, drained by a monitor; reference
//               model tracks residency per set/way. Honors
//               INSTR_CACHE_PERF_EN for the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_cache_sa;

  localparam int NSETS = 8;
  localparam int NWAYS = 2;

  logic         clk;
  logic         reset;
  logic [9:0]   address;
  logic         flush;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef INSTR_CACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  instr_cache_sa dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .flush        (flush),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef INSTR_CACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          fills;
  } txn_t;

  txn_t         sb_q[$];
  logic [127:0] mem [64];
  int           n_checks = 0;
  int           n_err    = 0;
  int           fixed_lat = 3;

  // Reference model: which line tags live in which way of each set
  bit           mv [NSETS][NWAYS];
  int           mt [NSETS][NWAYS];
  int           mp [NSETS];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  endtask

  task automatic abort(input string name);
    n_err++;
    $display("FAIL %s timed out", name);
    summary_and_finish();
  endtask

  function automatic void model_clear();
    for (int s = 0; s < NSETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < NWAYS; w++) mv[s][w] = 1'b0;
    end
  endfunction

  // Returns 1 if the access misses (and installs the line), 0 on a hit
  function automatic int model_access(input logic [9:0] a);
    int s;
    int tag;
    int victim;
    s   = (int'(a) / 16) % NSETS;
    tag = int'(a) / (16 * NSETS);
    for (int w = 0; w < NWAYS; w++)
      if (mv[s][w] && mt[s][w] == tag) return 0;
    victim = -1;
    for (int w = NWAYS - 1; w >= 0; w--)
      if (!mv[s][w]) victim = w;
    if (victim < 0) victim = mp[s];
    mv[s][victim] = 1'b1;
    mt[s][victim] = tag;
    mp[s] = (mp[s] + 1) % NWAYS;
    return 1;
  endfunction

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    logic [127:0] line;
    int wi;
    line = mem[int'(a) / 16];
    wi   = (int'(a) / 4) % 4;
    return line[wi*32 +: 32];
  endfunction

  // Called just after a rising edge: queue the expectation, drive address
  task automatic start_fetch(input logic [9:0] a, input int extra_fills);
    txn_t t;
    t.addr  = a;
    t.fills = model_access(a) + extra_fills;
    t.data  = mem_word(a);
    sb_q.push_back(t);
    address = a;
  endtask

  // Counts cycles (sampled on falling edges) until busywait drops
  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busywait) return;
      n++;
      if (n > 60) abort("fetch completion");
    end
  endtask

  task automatic fetch(input logic [9:0] a, output int n);
    @(posedge clk); #1;
    start_fetch(a, 0);
    wait_done(n);
  endtask

  task automatic wait_mem_read();
    for (int k = 0; k < 20 && !mem_read; k++) @(negedge clk);
    if (!mem_read) abort("mem_read request");
  endtask

  // Flush while idle, then refetch the held address
  task automatic flush_op();
    int n;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
`ifdef INSTR_CACHE_PERF_EN
    chk("hit_count after flush", hit_count, 0);
    chk("miss_count after flush", miss_count, 0);
`endif
    model_clear();
    start_fetch(address, 0);
    wait_done(n);
  endtask

  // Memory responder: fixed or random busy cycles, then one data cycle
  initial begin
    int cnt;
    cnt = -1;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        cnt = -1;
        mem_busywait = 1'b1;
      end else if (!mem_busywait) begin
        mem_busywait = 1'b1;
      end else if (mem_read) begin
        if (cnt < 0) cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          mem_busywait = 1'b0;
          mem_readdata = mem[mem_address];
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: counts line requests per fetch and checks completed fetches
  initial begin
    logic prev;
    int   fills;
    txn_t t;
    prev  = 1'b0;
    fills = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (mem_read && !prev && sb_q.size() > 0) begin
          fills++;
          chk("mem_address", mem_address, sb_q[0].addr / 16);
        end
        if (!busywait && sb_q.size() > 0) begin
          t = sb_q.pop_front();
          chk($sformatf("readdata@%0h", t.addr), readdata, t.data);
          chk($sformatf("line_fetches@%0h", t.addr), fills, t.fills);
          fills = 0;
        end
      end
      prev = mem_read;
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog expired");
    summary_and_finish();
  end

  // Main stimulus
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[0] = 128'h44444444_33333333_22222222_11111111;
    model_clear();
    reset   = 1'b0;
    flush   = 1'b0;
    address = '0;

    // Reset state: nothing cached, no request
    repeat (3) @(negedge clk);
    chk("reset busywait", busywait, 1);
    chk("reset mem_read", mem_read, 0);

    // Cold miss on 0x000 with three busy memory cycles
    @(posedge clk); #1;
    reset = 1'b1;
    start_fetch(10'h000, 0);
    wait_done(n);
    chk("miss latency cycles", n, 5);

    // Remaining words of the line hit without a stall
    fetch(10'h004, n); chk("hit 0x004 no stall", n, 0);
    fetch(10'h008, n); chk("hit 0x008 no stall", n, 0);
    fetch(10'h00C, n); chk("hit 0x00C no stall", n, 0);
`ifdef INSTR_CACHE_PERF_EN
    @(posedge clk); #1;
    chk("hit_count cold run", hit_count, 4);
    chk("miss_count cold run", miss_count, 1);
`endif
    flush_op();

    // Two-way conflict in set 0: third line evicts way 0
    fixed_lat = -1;
    fetch(10'h000, n);
    fetch(10'h080, n);
    fetch(10'h100, n);
    fetch(10'h080, n); chk("conflict 0x080 still hits", n, 0);
    fetch(10'h000, n); chk("conflict 0x000 misses", n > 0, 1);

    // Flush during a refill: fill discarded, access refetched
    fixed_lat = 3;
    @(posedge clk); #1;
    model_clear();
    start_fetch(10'h010, 1);
    wait_mem_read();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done(n);
    fetch(10'h000, n); chk("0x000 misses after flush", n > 0, 1);

    // Asynchronous reset two cycles into a refill
    @(posedge clk); #1;
    address = 10'h300;
    wait_mem_read();
    @(negedge clk);
    chk("mem_read before reset", mem_read, 1);
    reset = 1'b0;
    #1;
    chk("mem_read drops on reset", mem_read, 0);
    chk("busywait during reset", busywait, 1);
    @(posedge clk); #1;
    address = 10'h000;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clear();
    start_fetch(10'h000, 0);
    wait_done(n);
    chk("0x000 misses after reset", n > 0, 1);

    // Randomized fetches over four tags per set, occasional flushes
    fixed_lat = -1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 8) flush_op();
      else fetch(10'($urandom_range(0, 511)) & 10'h3FC, n);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb_q.size(), 0);
    summary_and_finish();
  end

endmodule
`default_nettype wire
